// File: rtl/ifetch_if.sv
// rtl/ifetch_if.sv - ifetch control, instruction-memory and IF/ID bundle
interface ifetch_if #(
    parameter int CNT_W = 16
) ();
    logic             start;
    logic             stall;
    logic             redirect;
    logic [15:0]      redirect_pc;
    logic [15:0]      iaddr;
    logic [15:0]      idata;
    logic             if_valid;
    logic [15:0]      if_instr;
    logic [15:0]      if_pc;
    logic [15:0]      if_pc_inc;
    logic             if_pred;
    logic [CNT_W-1:0] fetch_cnt;

    modport slave (
        input  start, stall, redirect, redirect_pc, idata,
        output iaddr, if_valid, if_instr, if_pc, if_pc_inc, if_pred, fetch_cnt
    );

    modport master (
        output start, stall, redirect, redirect_pc, idata,
        input  iaddr, if_valid, if_instr, if_pc, if_pc_inc, if_pred, fetch_cnt
    );
endinterface

// File: rtl/ifetch.sv
// rtl/ifetch.sv - pmips fetch stage: PC, IF/ID register, counter; IFETCH_BTFN_EN enables BTFN prediction
module ifetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic     clock,
    input  logic     reset,
    ifetch_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       state;
    logic [15:0]      pc;
    logic [15:0]      pc_inc;
    logic [15:0]      next_pc;
    logic             take;
    logic             advance;
    logic             if_valid_q;
    logic [15:0]      if_instr_q;
    logic [15:0]      if_pc_q;
    logic [15:0]      if_pc_inc_q;
    logic [CNT_W-1:0] fetch_cnt_q;

    // A fetch slot is consumed only in RUN with neither redirect nor stall.
    assign advance = (state == S_RUN) && !bus.redirect && !bus.stall;
    assign pc_inc  = pc + 16'd2;

`ifdef IFETCH_BTFN_EN
    logic [15:0] target;
    logic        if_pred_q;

    // Backward beq (negative offset) is predicted taken; target = pc+2+(sext(imm)<<1).
    always_comb begin
        target = pc_inc + {{8{bus.idata[6]}}, bus.idata[6:0], 1'b0};
        take   = (bus.idata[15:13] == 3'd2) && bus.idata[6];
    end

    // Prediction flag travels with the instruction into IF/ID; cleared by flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_pred_q <= 1'b0;
        end else if (state == S_RUN) begin
            if (bus.redirect)
                if_pred_q <= 1'b0;
            else if (!bus.stall)
                if_pred_q <= take;
        end
    end

    assign next_pc     = take ? target : pc_inc;
    assign bus.if_pred = if_pred_q;
`else
    assign take        = 1'b0;
    assign next_pc     = pc_inc;
    assign bus.if_pred = take;
`endif

    // FSM: IDLE waits for start, RUN is left only through reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            state <= S_IDLE;
        else if (state == S_IDLE && bus.start)
            state <= S_RUN;
    end

    // Program counter: redirect beats stall; otherwise advance to next_pc.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else if (state == S_RUN && bus.redirect)
            pc <= {bus.redirect_pc[15:1], 1'b0};
        else if (advance)
            pc <= next_pc;
    end

    // IF/ID register: flush to invalid NOP on redirect, load on advance, else hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            if_valid_q  <= 1'b0;
            if_instr_q  <= 16'h0000;
            if_pc_q     <= 16'h0000;
            if_pc_inc_q <= 16'h0000;
        end else if (state == S_RUN && bus.redirect) begin
            if_valid_q <= 1'b0;
            if_instr_q <= 16'h0000;
        end else if (advance) begin
            if_valid_q  <= 1'b1;
            if_instr_q  <= bus.idata;
            if_pc_q     <= pc;
            if_pc_inc_q <= pc_inc;
        end
    end

    // Counts every instruction written into IF/ID as valid; wraps naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            fetch_cnt_q <= '0;
        else if (advance)
            fetch_cnt_q <= fetch_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    assign bus.iaddr     = pc;
    assign bus.if_valid  = if_valid_q;
    assign bus.if_instr  = if_instr_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_pc_inc = if_pc_inc_q;
    assign bus.fetch_cnt = fetch_cnt_q;
endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - scoreboard bench for ifetch
module tb_ifetch;
    logic clock = 1'b0;
    logic reset = 1'b0;

    ifetch_if #(.CNT_W(16)) bus ();

    ifetch #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Multiply-by-add program image plus backward/forward beq words.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        case (a)
            16'd0:   mem_word = 16'h6103;
            16'd2:   mem_word = 16'h6184;
            16'd4:   mem_word = 16'h0510;
            16'd6:   mem_word = 16'h6DFF;
            16'd8:   mem_word = 16'h407B;
            16'd10:  mem_word = 16'h6FFF;
            16'd12:  mem_word = 16'h1234;
            16'd14:  mem_word = 16'hA5A5;
            16'd16:  mem_word = 16'h407B;
            16'd18:  mem_word = 16'h4105;
            default: mem_word = {3'b000, a[12:0]};
        endcase
    endfunction

    assign bus.idata = mem_word(bus.iaddr);

    typedef struct {
        logic [15:0] iaddr;
        logic        valid;
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] inc;
        logic        pred;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];
    exp_t m;
    logic m_run;
    int   tests  = 0;
    int   failed = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_run   = 1'b0;
        m.iaddr = 16'h0000;
        m.valid = 1'b0;
        m.instr = 16'h0000;
        m.pc    = 16'h0000;
        m.inc   = 16'h0000;
        m.pred  = 1'b0;
        m.cnt   = 16'h0000;
    endtask

    task automatic compare_all(input string tag, input exp_t e);
        check_eq({tag, ".iaddr"}, 32'(bus.iaddr), 32'(e.iaddr));
        check_eq({tag, ".valid"}, 32'(bus.if_valid), 32'(e.valid));
        check_eq({tag, ".instr"}, 32'(bus.if_instr), 32'(e.instr));
        check_eq({tag, ".pc"}, 32'(bus.if_pc), 32'(e.pc));
        check_eq({tag, ".inc"}, 32'(bus.if_pc_inc), 32'(e.inc));
        check_eq({tag, ".pred"}, 32'(bus.if_pred), 32'(e.pred));
        check_eq({tag, ".cnt"}, 32'(bus.fetch_cnt), 32'(e.cnt));
    endtask

    // Advance the reference model by one edge and queue what the DUT should show.
    task automatic model_edge(input logic st, input logic stl, input logic rd, input logic [15:0] rpc);
        logic [15:0] w;
        logic        tk;
        if (!m_run) begin
            if (st) m_run = 1'b1;
        end else if (rd) begin
            m.iaddr = {rpc[15:1], 1'b0};
            m.valid = 1'b0;
            m.instr = 16'h0000;
            m.pred  = 1'b0;
        end else if (!stl) begin
            w = mem_word(m.iaddr);
`ifdef IFETCH_BTFN_EN
            tk = (w[15:13] == 3'd2) && w[6];
`else
            tk = 1'b0;
`endif
            m.instr = w;
            m.pc    = m.iaddr;
            m.inc   = m.iaddr + 16'd2;
            m.valid = 1'b1;
            m.pred  = tk;
            m.cnt   = m.cnt + 16'd1;
            m.iaddr = tk ? (m.iaddr + 16'd2 + {{8{w[6]}}, w[6:0], 1'b0}) : (m.iaddr + 16'd2);
        end
        sb.push_back(m);
    endtask

    task automatic step(input logic st, input logic stl, input logic rd, input logic [15:0] rpc);
        exp_t e;
        bus.start       = st;
        bus.stall       = stl;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        model_edge(st, stl, rd, rpc);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        compare_all("sb", e);
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        model_reset();

        // Reset and IDLE
        @(posedge clock);
        @(posedge clock);
        #1;
        compare_all("reset", m);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            check_eq("idle_iaddr", 32'(bus.iaddr), 32'h0);
            check_eq("idle_valid", 32'(bus.if_valid), 32'h0);
            check_eq("idle_cnt", 32'(bus.fetch_cnt), 32'h0);
        end

        // Sequential fetch
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        check_eq("start_no_fetch", 32'(bus.if_valid), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            check_eq("seq_pc", 32'(bus.if_pc), 32'(2 * i));
            check_eq("seq_valid", 32'(bus.if_valid), 32'h1);
            if (i == 0) check_eq("seq_instr0", 32'(bus.if_instr), 32'h6103);
        end
        check_eq("seq_cnt5", 32'(bus.fetch_cnt), 32'd5);

        // Stall while if_pc=4
        step(1'b0, 1'b0, 1'b1, 16'h0000);
        check_eq("rd0_bubble", 32'(bus.if_valid), 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("pre_stall_pc", 32'(bus.if_pc), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            check_eq("stall_iaddr", 32'(bus.iaddr), 32'd6);
            check_eq("stall_pc", 32'(bus.if_pc), 32'd4);
            check_eq("stall_cnt", 32'(bus.fetch_cnt), 32'd8);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("unstall_pc", 32'(bus.if_pc), 32'd6);

        // Redirect beats stall, odd target bit dropped
        step(1'b0, 1'b1, 1'b1, 16'h0009);
        check_eq("rdst_iaddr", 32'(bus.iaddr), 32'd8);
        check_eq("rdst_valid", 32'(bus.if_valid), 32'h0);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("rdst_pc", 32'(bus.if_pc), 32'd8);
        check_eq("rdst_instr", 32'(bus.if_instr), 32'h407B);

        // Backward beq at pc=16
        step(1'b0, 1'b0, 1'b1, 16'd16);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("beq_instr", 32'(bus.if_instr), 32'h407B);
`ifdef IFETCH_BTFN_EN
        check_eq("beq_iaddr", 32'(bus.iaddr), 32'd8);
        check_eq("beq_pred", 32'(bus.if_pred), 32'h1);
`else
        check_eq("beq_iaddr", 32'(bus.iaddr), 32'd18);
        check_eq("beq_pred", 32'(bus.if_pred), 32'h0);
`endif
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("beq_no_bubble", 32'(bus.if_valid), 32'h1);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        // PC wrap at 16'hFFFE
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("wrap_iaddr", 32'(bus.iaddr), 32'h0);
        check_eq("wrap_inc", 32'(bus.if_pc_inc), 32'h0);

        // Async reset mid-run with if_pc=12
        step(1'b0, 1'b0, 1'b1, 16'd12);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("pre_rst_pc", 32'(bus.if_pc), 32'd12);
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst", m);
        #2;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            check_eq("post_rst_idle", 32'(bus.if_valid), 32'h0);
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        check_eq("restart_pc", 32'(bus.if_pc), 32'h0);
        check_eq("restart_cnt", 32'(bus.fetch_cnt), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the 16-bit pmips datapath. Owns the program counter and drives the instruction memory's byte address. Registers the returned instruction word into the IF/ID pipeline register for the decode stage. Handles start-up, stalls, downstream branch redirects/flushes and a fetched-instruction counter, with an optional static backward-taken branch predictor.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset; must be even.
- CNT_W, 16, width of the fetched-instruction counter.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  leave IDLE and begin fetching; sampled only in IDLE.
- stall  in  1  hold PC and IF/ID register (decode back-pressure).
- redirect  in  1  branch resolved to a PC other than the one fetched; flush and reload.
- redirect_pc  in  16  new PC when redirect=1; bit 0 ignored (forced 0).
- iaddr  out  16  byte address to instruction memory; equals the PC register.
- idata  in  16  instruction word from memory, combinational from iaddr.
- if_valid  out  1  IF/ID holds a real instruction.
- if_instr  out  16  IF/ID instruction; 16'h0000 (NOP) when invalid.
- if_pc  out  16  address of if_instr.
- if_pc_inc  out  16  if_pc + 2.
- if_pred  out  1  fetch predicted this beq taken (0 when the predictor is compiled out).
- fetch_cnt  out  CNT_W  count of instructions written into IF/ID as valid; wraps.

## Operation
- FSM states: IDLE, RUN.
  - Reset -> IDLE.
  - IDLE -> RUN when start=1.
  - RUN has no exit; only reset returns to IDLE.
- Reset values: pc=RESET_PC, iaddr=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_inc=0, if_pred=0, fetch_cnt=0, state=IDLE.
- IDLE: PC holds. IF/ID holds invalid NOP. stall and redirect are ignored.
- RUN, each clock edge, highest priority first:
  1. **redirect=1:** pc <= {redirect_pc[15:1],1'b0}. IF/ID <= invalid NOP (if_valid=0, if_instr=0, if_pred=0). fetch_cnt unchanged. Overrides stall.
  2. **stall=1:** pc, IF/ID and fetch_cnt all hold.
  3. **Otherwise:**
     - if_instr <= idata, if_pc <= pc, if_pc_inc <= pc+2, if_valid <= 1, fetch_cnt <= fetch_cnt+1.
     - pc <= next_pc, where next_pc = pc+2, or the predicted target (see Configuration).
- Instruction format: op[15:13], rs[12:10], rt[9:7], imm[6:0]. beq is op=3'd2.
- Branch target = pc + 2 + (sign_extend(imm) << 1), modulo 2^16.
- PC arithmetic is 16-bit and wraps: 16'hFFFE + 2 = 16'h0000.
- Reset asserted mid-operation clears everything immediately, asynchronously. No partial state survives.

## Timing
- Fetch latency 1 cycle: the instruction at iaddr=A in cycle n appears on if_instr/if_pc=A in cycle n+1.
- Steady state: one instruction per cycle.
- First valid IF/ID is one cycle after the edge on which start is sampled; that instruction is from RESET_PC.
- Redirect: one bubble. if_valid=0 in cycle n+1, and the instruction from redirect_pc is valid in cycle n+2.
- Predicted-taken beq: zero bubbles; the target instruction is valid the very next cycle.
- Stall during RUN: outputs frozen cycle-for-cycle. If redirect is also asserted, redirect wins.

## Configuration
- Macro: `IFETCH_BTFN_EN`.
- **Defined:**
  - Static backward-taken/forward-not-taken prediction.
  - Applies when idata[15:13]==3'd2 and idata[6]==1 (negative offset) in a non-stalled, non-redirected RUN cycle.
  - Then next_pc = branch target and if_pred <= 1.
  - All other cases: next_pc = pc+2 and if_pred <= 0.
  - Downstream must use if_pred to decide whether a mispredict redirect is needed.
- **Undefined:** next_pc is always pc+2, and if_pred is constant 0. All branches resolve through redirect.

## Test plan
- **Reset/IDLE:** hold reset low, then release with start=0 for 5 cycles.
  - iaddr=0, if_valid=0, if_instr=0 and fetch_cnt=0 throughout.
- **Sequential fetch:** pulse start with memory loaded with the team's multiply-by-add test program.
  - if_pc = 0,2,4,6,8 on consecutive cycles.
  - if_instr at pc=0 is 16'h6103 (addi $2,$0,3).
  - fetch_cnt reaches 5 after 5 valid cycles.
- **Stall:** assert stall for 3 cycles while if_pc=4.
  - iaddr=6 and if_pc=4 held for all 3 cycles; fetch_cnt unchanged.
  - On release, if_pc=6 the next cycle.
- **Redirect vs stall:** assert stall=1 and redirect=1 with redirect_pc=16'h0009.
  - Next cycle: iaddr=8, if_valid=0.
  - Following cycle: if_pc=8, if_instr=16'h407B.
- **Backward beq with macro defined:** fetch 16'h407B at pc=16.
  - Next cycle: iaddr=8, if_pred=1, no bubble.
  - With the macro undefined: iaddr=18 and if_pred=0.
- **Async reset mid-run:** drop reset during a RUN cycle with if_pc=12.
  - All outputs reach their reset values before the next clock edge.
  - State is IDLE afterwards; start is needed again.
